// File: rtl/sdram_burst_sched.sv
// rtl/sdram_burst_sched.sv - refresh/write/read burst scheduler in front of the SDRAM command core
// Optional feature macro RD_LOOP_EN: readback wraps to address 0 and never reports RD_DONE.
module sdram_burst_sched #(
  parameter int unsigned         BURST_LEN  = 8,
  parameter int unsigned         ADDR_W     = 22,
  parameter logic [ADDR_W-1:0]   END_ADDR   = 'h000100,
  parameter int unsigned         REF_PERIOD = 780
) (
  input  logic              CLK_100M,
  input  logic              RST_N,
  input  logic              SDRAM_WR_REQ,
  input  logic              SDRAM_RD_REQ,
  input  logic              CMD_READY,
  input  logic              CORE_BEAT,
  input  logic              CORE_DONE,
  output logic              CMD_VALID,
  output logic [1:0]        CMD_TYPE,
  output logic [ADDR_W-1:0] CMD_ADDR,
  output logic              SDRAM_WR_ACK,
  output logic              SDRAM_RD_ACK,
  output logic              WR_DONE,
  output logic              RD_DONE,
  output logic              REF_MISS
);

  localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [CNT_W-1:0]  REF_LAST = CNT_W'(REF_PERIOD - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BURST_LEN);
  localparam logic [1:0] T_REF = 2'b00;
  localparam logic [1:0] T_WR  = 2'b01;
  localparam logic [1:0] T_RD  = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t            state;
  logic [CNT_W-1:0]  ref_cnt;
  logic              ref_pend;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_next;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W-1:0] rd_upd;
  logic              ref_wrap;
  logic              ref_accept;

  assign ref_wrap   = (ref_cnt == REF_LAST);
  assign ref_accept = (state == ISSUE) && CMD_READY && (CMD_TYPE == T_REF);
  assign wr_next    = wr_addr + STEP;
  assign rd_next    = rd_addr + STEP;

  // Strobes follow the core's beats directly so the FIFOs see no extra latency.
  assign SDRAM_WR_ACK = (state == BUSY) && (CMD_TYPE == T_WR) && CORE_BEAT;
  assign SDRAM_RD_ACK = (state == BUSY) && (CMD_TYPE == T_RD) && CORE_BEAT;

`ifdef RD_LOOP_EN
  assign RD_DONE = 1'b0;
  assign rd_upd  = (rd_next == END_ADDR) ? '0 : rd_next;
`else
  assign rd_upd  = rd_next;

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N)
      RD_DONE <= 1'b0;
    else if (state == BUSY && CORE_DONE && CMD_TYPE == T_RD && rd_next == END_ADDR)
      RD_DONE <= 1'b1;
  end
`endif

  // A wrap wins over a same-cycle acceptance so that a period is never lost.
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
      REF_MISS <= 1'b0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + CNT_W'(1);
      if (ref_wrap) begin
        ref_pend <= 1'b1;
        if (ref_pend)
          REF_MISS <= 1'b1;
      end else if (ref_accept) begin
        ref_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      CMD_VALID <= 1'b0;
      CMD_TYPE  <= T_REF;
      CMD_ADDR  <= '0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      WR_DONE   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ref_pend) begin
            CMD_TYPE  <= T_REF;
            CMD_ADDR  <= '0;
            CMD_VALID <= 1'b1;
            state     <= ISSUE;
          end else if (SDRAM_WR_REQ && !WR_DONE) begin
            CMD_TYPE  <= T_WR;
            CMD_ADDR  <= wr_addr;
            CMD_VALID <= 1'b1;
            state     <= ISSUE;
          end else if (SDRAM_RD_REQ && WR_DONE && !RD_DONE) begin
            CMD_TYPE  <= T_RD;
            CMD_ADDR  <= rd_addr;
            CMD_VALID <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (CMD_READY) begin
            CMD_VALID <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (CORE_DONE) begin
            state <= IDLE;
            if (CMD_TYPE == T_WR) begin
              wr_addr <= wr_next;
              if (wr_next == END_ADDR)
                WR_DONE <= 1'b1;
            end else if (CMD_TYPE == T_RD) begin
              rd_addr <= rd_upd;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// tb/tb_sdram_burst_sched.sv - randomized self-checking bench for sdram_burst_sched
// Honours RD_LOOP_EN the same way as the design.
module tb_sdram_burst_sched;

  localparam int BL = 8;
  localparam int AW = 22;
  localparam int RP = 60;
  localparam int END_W = 32;
  localparam logic [AW-1:0] END_A = AW'(END_W);

  logic          CLK_100M = 1'b0;
  logic          RST_N = 1'b0;
  logic          SDRAM_WR_REQ = 1'b0;
  logic          SDRAM_RD_REQ = 1'b0;
  logic          CMD_READY = 1'b0;
  logic          CORE_BEAT = 1'b0;
  logic          CORE_DONE = 1'b0;
  logic          CMD_VALID;
  logic [1:0]    CMD_TYPE;
  logic [AW-1:0] CMD_ADDR;
  logic          SDRAM_WR_ACK;
  logic          SDRAM_RD_ACK;
  logic          WR_DONE;
  logic          RD_DONE;
  logic          REF_MISS;

  sdram_burst_sched #(
    .BURST_LEN(BL), .ADDR_W(AW), .END_ADDR(END_A), .REF_PERIOD(RP)
  ) dut (
    .CLK_100M(CLK_100M), .RST_N(RST_N),
    .SDRAM_WR_REQ(SDRAM_WR_REQ), .SDRAM_RD_REQ(SDRAM_RD_REQ),
    .CMD_READY(CMD_READY), .CORE_BEAT(CORE_BEAT), .CORE_DONE(CORE_DONE),
    .CMD_VALID(CMD_VALID), .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR),
    .SDRAM_WR_ACK(SDRAM_WR_ACK), .SDRAM_RD_ACK(SDRAM_RD_ACK),
    .WR_DONE(WR_DONE), .RD_DONE(RD_DONE), .REF_MISS(REF_MISS)
  );

  always #5 CLK_100M = ~CLK_100M;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_ref_acc = 0;
  int wr_acks = 0;
  int rd_acks = 0;
  int n_wr = 0;
  int n_rd = 0;
  logic          exp_miss = 1'b0;
  logic          exp_wr_done = 1'b0;
  logic          exp_rd_done = 1'b0;
  logic [AW-1:0] exp_wr_addr = '0;
  logic [AW-1:0] exp_rd_addr = '0;
  logic [1:0]    obs_type = 2'b11;
  logic [AW-1:0] obs_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Refresh is owed after edge m when the latest period boundary is not older than the latest refresh acceptance.
  function automatic logic pend_at(input int m);
    int w;
    w = (m / RP) * RP;
    return (w > 0) && (w >= last_ref_acc);
  endfunction

  task automatic tick();
    @(posedge CLK_100M);
    if (RST_N) cyc++;
    @(negedge CLK_100M);
    if (cyc > 0 && (cyc % RP) == 0 && pend_at(cyc - 1)) exp_miss = 1'b1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    SDRAM_WR_REQ = 1'b0;
    SDRAM_RD_REQ = 1'b0;
    CMD_READY = 1'b0;
    CORE_BEAT = 1'b0;
    CORE_DONE = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        32'({CMD_VALID, CMD_TYPE, CMD_ADDR, SDRAM_WR_ACK, SDRAM_RD_ACK, WR_DONE, RD_DONE, REF_MISS}), 32'd0);
    cyc = 0; last_ref_acc = 0; wr_acks = 0; rd_acks = 0; n_wr = 0; n_rd = 0;
    exp_miss = 1'b0; exp_wr_done = 1'b0; exp_rd_done = 1'b0;
    exp_wr_addr = '0; exp_rd_addr = '0;
    RST_N = 1'b1;
  endtask

  // Plays the core for one command: optional ISSUE stall, beats, optional late CORE_DONE or mid-burst reset.
  task automatic serve(input int hold, input int done_wait, input int abort_beat);
    logic [1:0]    et;
    logic [AW-1:0] ea;
    int t;
    int nb;
    t = 0;
    while (CMD_VALID !== 1'b1 && t < 400) begin
      tick();
      t++;
    end
    chk("cmd_wait_bound", 32'(t < 400), 32'd1);
    if (t >= 400) return;
    if (pend_at(cyc - 1)) begin
      et = 2'b00; ea = '0;
    end else if (SDRAM_WR_REQ && !exp_wr_done) begin
      et = 2'b01; ea = exp_wr_addr;
    end else if (SDRAM_RD_REQ && exp_wr_done && !exp_rd_done) begin
      et = 2'b10; ea = exp_rd_addr;
    end else begin
      et = 2'b11; ea = '0;
    end
    obs_type = CMD_TYPE;
    obs_addr = CMD_ADDR;
    chk("cmd_type", 32'(CMD_TYPE), 32'(et));
    chk("cmd_addr", 32'(CMD_ADDR), 32'(ea));
    for (int i = 0; i < hold; i++) begin
      CORE_BEAT = 1'($urandom);
      CORE_DONE = 1'($urandom);
      #1;
      chk("issue_no_ack", 32'({SDRAM_WR_ACK, SDRAM_RD_ACK}), 32'd0);
      tick();
      chk("issue_stable", 32'({CMD_VALID, CMD_TYPE, CMD_ADDR}), 32'({1'b1, et, ea}));
    end
    CORE_BEAT = 1'b0;
    CORE_DONE = 1'b0;
    CMD_READY = 1'b1;
    tick();
    CMD_READY = 1'b0;
    if (et == 2'b00) last_ref_acc = cyc;
    chk("valid_drop", 32'(CMD_VALID), 32'd0);
    nb = (et == 2'b00) ? 2 : BL;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 2)) tick();
      CORE_BEAT = 1'b1;
      if (b == abort_beat) begin
        RST_N = 1'b0;
        #1;
        chk("async_reset_outputs",
            32'({CMD_VALID, CMD_TYPE, CMD_ADDR, SDRAM_WR_ACK, SDRAM_RD_ACK, WR_DONE, RD_DONE, REF_MISS}), 32'd0);
        CORE_BEAT = 1'b0;
        return;
      end
      #1;
      chk("wr_ack_beat", 32'(SDRAM_WR_ACK), 32'(et == 2'b01));
      chk("rd_ack_beat", 32'(SDRAM_RD_ACK), 32'(et == 2'b10));
      wr_acks += int'(SDRAM_WR_ACK);
      rd_acks += int'(SDRAM_RD_ACK);
      tick();
      CORE_BEAT = 1'b0;
    end
    repeat (done_wait) tick();
    CORE_DONE = 1'b1;
    tick();
    CORE_DONE = 1'b0;
    if (et == 2'b01) begin
      n_wr++;
      exp_wr_addr = AW'((n_wr * BL) % (1 << AW));
      if (exp_wr_addr == END_A) exp_wr_done = 1'b1;
    end else if (et == 2'b10) begin
      n_rd++;
`ifdef RD_LOOP_EN
      exp_rd_addr = AW'((n_rd * BL) % END_W);
`else
      exp_rd_addr = AW'(n_rd * BL);
      if (exp_rd_addr == END_A) exp_rd_done = 1'b1;
`endif
    end
    chk("wr_done", 32'(WR_DONE), 32'(exp_wr_done));
    chk("rd_done", 32'(RD_DONE), 32'(exp_rd_done));
    chk("idle_gap", 32'(CMD_VALID), 32'd0);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (CMD_VALID === 1'b1) begin
        serve($urandom_range(0, 2), 0, -1);
        chk("quiet_only_refresh", 32'(obs_type), 32'd0);
      end
    end
  endtask

  initial begin
    int k;
    do_reset();

    // Reset arrives on the third beat of the very first write burst.
    SDRAM_WR_REQ = 1'b1;
    serve(0, 0, 2);
    do_reset();

    SDRAM_WR_REQ = 1'b1;
    serve(5, 0, -1);
    chk("first_write_after_reset", 32'(obs_addr), 32'd0);

    // Hold off writes until a refresh is owed, then request both at once.
    SDRAM_WR_REQ = 1'b0;
    k = 0;
    while (!pend_at(cyc) && k < 400) begin
      tick();
      k++;
    end
    SDRAM_WR_REQ = 1'b1;
    serve($urandom_range(0, 3), 0, -1);
    chk("refresh_first", 32'(obs_type), 32'd0);
    serve($urandom_range(0, 3), 0, -1);
    chk("write_after_refresh", 32'(obs_type), 32'd1);

    // Stretch one burst across two refresh periods.
    serve($urandom_range(0, 3), 2 * RP, -1);
    chk("ref_miss_set", 32'(REF_MISS), 32'(exp_miss));
    serve($urandom_range(0, 3), 0, -1);
    chk("refresh_after_stall", 32'(obs_type), 32'd0);

    k = 0;
    while (!exp_wr_done && k < 20) begin
      serve($urandom_range(0, 4), 0, -1);
      k++;
    end
    chk("write_burst_count", 32'(n_wr), 32'(END_W / BL));
    chk("wr_ack_total", 32'(wr_acks), 32'(END_W));
    chk("wr_done_final", 32'(WR_DONE), 32'd1);

    quiet(2 * RP);

    SDRAM_RD_REQ = 1'b1;
    k = 0;
    while (n_rd < END_W / BL && k < 20) begin
      serve($urandom_range(0, 4), 0, -1);
      k++;
    end
    chk("rd_ack_total", 32'(rd_acks), 32'(END_W));
`ifdef RD_LOOP_EN
    k = 0;
    obs_type = 2'b11;
    while (obs_type != 2'b10 && k < 4) begin
      serve($urandom_range(0, 2), 0, -1);
      k++;
    end
    chk("read_wraps_to_zero", 32'({obs_type, obs_addr}), 32'({2'b10, AW'(0)}));
    chk("rd_done_tied_low", 32'(RD_DONE), 32'd0);
`else
    chk("rd_done_set", 32'(RD_DONE), 32'd1);
    quiet(2 * RP);
    chk("rd_done_sticky", 32'(RD_DONE), 32'(exp_rd_done));
    chk("read_count_stops", 32'(n_rd), 32'(END_W / BL));
`endif
    chk("ref_miss_sticky", 32'(REF_MISS), 32'(exp_miss));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_burst_sched.md
Name: sdram_burst_sched

Overview:
- Single-clock scheduler in the CLK_100M domain, between the SDRAM FIFO control logic and the low-level SDRAM command core.
- Arbitrates auto-refresh, write-burst requests (SDRAM_WR_REQ) and read-burst requests (SDRAM_RD_REQ).
- Generates burst addresses and gates per-beat data strobes into SDRAM_WR_ACK / SDRAM_RD_ACK.
- Owns the sticky WR_DONE flag that switches the system from fill phase to readback phase.

Parameters:
- BURST_LEN, 8: words per burst; address step per completed burst; power of two.
- ADDR_W, 22: word-address width.
- END_ADDR, 22'h000100: word address at which the fill region ends (exclusive); multiple of BURST_LEN.
- REF_PERIOD, 780: cycles between refresh requests (7.8 us at 100 MHz).

Ports:
- CLK_100M  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- SDRAM_WR_REQ  input  1  write FIFO holds at least one burst (level).
- SDRAM_RD_REQ  input  1  read FIFO has room for a burst (level).
- CMD_READY  input  1  core idle; accepts a command when CMD_VALID is high in the same cycle.
- CORE_BEAT  input  1  one-cycle pulse per data beat of the current burst.
- CORE_DONE  input  1  one-cycle pulse at burst/refresh completion.
- CMD_VALID  output  1  command request to the core.
- CMD_TYPE  output  2  00 refresh, 01 write, 10 read.
- CMD_ADDR  output  ADDR_W  burst start word address.
- SDRAM_WR_ACK  output  1  write FIFO read strobe; equals CORE_BEAT in state WR.
- SDRAM_RD_ACK  output  1  read FIFO write strobe; equals CORE_BEAT in state RD.
- WR_DONE  output  1  sticky; fill region completely written.
- RD_DONE  output  1  readback finished (RD_LOOP_EN absent only; otherwise tied 0).
- REF_MISS  output  1  sticky; refresh period expired while a refresh was already pending.

Behaviour:
- Reset values: all outputs 0, state IDLE, wr_addr=0, rd_addr=0, ref_cnt=0, ref_pend=0.
- Refresh timer:
  - ref_cnt counts 0..REF_PERIOD-1 and wraps.
  - Wrap sets ref_pend. Wrap while ref_pend=1 also sets REF_MISS.
  - ref_pend clears on refresh command acceptance. Wrap and acceptance in the same cycle leave ref_pend=1.
- States: IDLE, ISSUE, BUSY.
- IDLE arbitration, fixed priority refresh > write > read:
  - Write eligible only when WR_DONE=0.
  - Read eligible only when WR_DONE=1 and RD_DONE=0.
  - On a win, register CMD_TYPE and CMD_ADDR (write: wr_addr; read: rd_addr; refresh: 0), go to ISSUE with CMD_VALID=1 from the next cycle.
- ISSUE:
  - CMD_VALID, CMD_TYPE and CMD_ADDR are held stable until CMD_READY=1.
  - On acceptance, deassert CMD_VALID next cycle and go to BUSY.
- BUSY:
  - ACK strobes are combinational from CORE_BEAT gated by the registered CMD_TYPE: zero added latency, no strobes for refresh.
  - CORE_DONE returns to IDLE and updates:
    - write: wr_addr += BURST_LEN; if new wr_addr == END_ADDR, set WR_DONE.
    - read: rd_addr += BURST_LEN; at END_ADDR apply the optional-feature rule.
- Arbitration restarts the cycle after returning to IDLE, so there is at least one idle cycle between bursts.
- Requests are sampled only in IDLE. Request deassertion during ISSUE or BUSY has no effect; the burst completes.
- Address arithmetic is ADDR_W-bit unsigned and modulo 2^ADDR_W.
- Beats are not counted; the core defines burst length. CORE_BEAT or CORE_DONE outside BUSY is ignored.
- Reset mid-burst: immediate return to reset values. A partial burst is not resumed.

Optional Feature:
- Macro RD_LOOP_EN.
- Defined: rd_addr wraps to 0 on reaching END_ADDR; readback loops continuously; RD_DONE tied 0.
- Undefined: on reaching END_ADDR, rd_addr holds at END_ADDR and RD_DONE sets (sticky). Later SDRAM_RD_REQ is ignored; refresh continues.

Test Plan:
- SDRAM_WR_REQ=1, CMD_READY=1, 8 beats plus CORE_DONE per burst, END_ADDR=32 -> four write commands at CMD_ADDR 0, 8, 16, 24; 32 SDRAM_WR_ACK pulses; WR_DONE rises the cycle after the 4th CORE_DONE; later write requests ignored.
- ref_cnt wraps while SDRAM_WR_REQ=1 in IDLE -> CMD_TYPE=00 issued first, no ACK strobes during it, then write at the current wr_addr.
- CMD_READY held 0 for 5 cycles in ISSUE -> CMD_VALID, CMD_TYPE and CMD_ADDR stable all 5 cycles; BUSY entered after CMD_READY=1.
- WR_DONE=1, SDRAM_RD_REQ=1, END_ADDR=32 -> reads at 0, 8, 16, 24, then 0 (RD_LOOP_EN defined), or RD_DONE=1 with no 5th read (undefined).
- CORE_DONE withheld for 2*REF_PERIOD cycles -> REF_MISS=1 and stays 1; a single refresh is issued after completion.
- RST_N low during the 3rd beat of a write burst -> all outputs 0 asynchronously; after release, first write at CMD_ADDR 0.
